// File: rtl/apu_noise_pkg.sv
// apu_noise_pkg: register map, noise period table and length table shared
// by the noise channel and its testbench-facing helpers.
package apu_noise_pkg;

  // Register addresses within the channel's 4-byte window
  localparam logic [1:0] ADDR_CONTROL     = 2'd0;
  localparam logic [1:0] ADDR_CUSTOM_LO   = 2'd1;
  localparam logic [1:0] ADDR_SETUP       = 2'd2;
  localparam logic [1:0] ADDR_LENGTH_LOAD = 2'd3;

  // Timer reload values selected by SETUP[3:0]
  localparam logic [11:0] NOISE_PERIOD_TABLE [16] = '{
    12'd3,   12'd7,   12'd15,  12'd31,  12'd63,   12'd95,   12'd127,  12'd159,
    12'd201, 12'd253, 12'd379, 12'd507, 12'd761,  12'd1015, 12'd2033, 12'd4067
  };

  // Length counter load values selected by LENGTH_LOAD[7:3]
  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  function automatic logic [11:0] noise_period(input logic [3:0] idx);
    return NOISE_PERIOD_TABLE[idx];
  endfunction

  function automatic logic [7:0] length_value(input logic [4:0] idx);
    return LEN_TABLE[idx];
  endfunction

endpackage

// File: rtl/apu_noise_channel_ext_envelope.sv
// apu_envelope_unit: start flag, divider and decay counter clocked by the
// quarter-frame strobe, plus the constant-volume / decay level mux.
module apu_envelope_unit
  import apu_noise_pkg::*;
#(
  parameter int VOL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             quarter_frame_i,
  input  logic             start_set_i,
  input  logic             loop_i,
  input  logic             const_vol_i,
  input  logic [VOL_W-1:0] volume_i,
  output logic [VOL_W-1:0] level_o
);

  localparam logic [VOL_W-1:0] DECAY_MAX = {VOL_W{1'b1}};

  logic             r_start;
  logic [VOL_W-1:0] r_divider;
  logic [VOL_W-1:0] r_decay;

  // Start flag: a length-load write sets it even if a quarter strobe would
  // consume it in the same cycle; the strobe then sees it next time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_start <= 1'b0;
    end else if (start_set_i) begin
      r_start <= 1'b1;
    end else if (quarter_frame_i) begin
      r_start <= 1'b0;
    end
  end

  // Divider and decay advance only on quarter-frame strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_divider <= '0;
      r_decay   <= '0;
    end else if (quarter_frame_i) begin
      if (r_start) begin
        r_decay   <= DECAY_MAX;
        r_divider <= volume_i;
      end else if (r_divider == '0) begin
        r_divider <= volume_i;
        if (r_decay != '0) begin
          r_decay <= r_decay - 1'b1;
        end else if (loop_i) begin
          r_decay <= DECAY_MAX;
        end
      end else begin
        r_divider <= r_divider - 1'b1;
      end
    end
  end

  assign level_o = const_vol_i ? volume_i : r_decay;

endmodule

// File: rtl/apu_noise_channel_ext.sv
// apu_noise_channel_ext: LFSR noise channel with table or custom timer
// period, length counter, envelope and registered scaled output.
// Build option: define APU_NOISE_CUSTOM_PERIOD_EN to include the CUSTOM_LO
// register and the SETUP[6] custom-period select; otherwise the period
// always comes from the table.
module apu_noise_channel_ext
  import apu_noise_pkg::*;
#(
  parameter int LFSR_W    = 15,
  parameter int LONG_TAP  = 1,
  parameter int SHORT_TAP = 6,
  parameter int TIMER_W   = 12,
  parameter int VOL_W     = 4,
  parameter int OUT_W     = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             channel_regs_wr_i,
  input  logic [1:0]       channel_regs_addr_i,
  input  logic [7:0]       channel_regs_wr_data_i,
  input  logic             half_frame_i,
  input  logic             quarter_frame_i,
  input  logic             channel_enabled_i,
  output logic             channel_is_active_o,
  output logic [OUT_W-1:0] channel_output_o
);

  // Configuration registers
  logic       r_halt;
  logic       r_const_vol;
  logic [3:0] r_volume;
  logic       r_mode;
  logic [3:0] r_period_idx;

  // Datapath state
  logic [TIMER_W-1:0] r_timer;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [7:0]         r_length;
  logic [OUT_W-1:0]   r_out;

  logic               w_wr_ctrl;
  logic               w_wr_setup;
  logic               w_wr_len;
  logic [TIMER_W-1:0] w_period;
  logic               w_tick;
  logic               w_fb;
  logic [VOL_W-1:0]   w_level;
  logic [OUT_W-1:0]   w_scaled;

  assign w_wr_ctrl  = channel_regs_wr_i && (channel_regs_addr_i == ADDR_CONTROL);
  assign w_wr_setup = channel_regs_wr_i && (channel_regs_addr_i == ADDR_SETUP);
  assign w_wr_len   = channel_regs_wr_i && (channel_regs_addr_i == ADDR_LENGTH_LOAD);

  // CONTROL and SETUP register writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_halt       <= 1'b0;
      r_const_vol  <= 1'b0;
      r_volume     <= 4'd0;
      r_mode       <= 1'b0;
      r_period_idx <= 4'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_halt      <= channel_regs_wr_data_i[5];
        r_const_vol <= channel_regs_wr_data_i[4];
        r_volume    <= channel_regs_wr_data_i[3:0];
      end
      if (w_wr_setup) begin
        r_mode       <= channel_regs_wr_data_i[7];
        r_period_idx <= channel_regs_wr_data_i[3:0];
      end
    end
  end

`ifdef APU_NOISE_CUSTOM_PERIOD_EN
  logic       r_custom_sel;
  logic [7:0] r_custom_lo;
  logic       w_wr_custom;

  assign w_wr_custom = channel_regs_wr_i && (channel_regs_addr_i == ADDR_CUSTOM_LO);

  // Custom period low byte and select bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_custom_sel <= 1'b0;
      r_custom_lo  <= 8'd0;
    end else begin
      if (w_wr_custom) begin
        r_custom_lo <= channel_regs_wr_data_i;
      end
      if (w_wr_setup) begin
        r_custom_sel <= channel_regs_wr_data_i[6];
      end
    end
  end

  assign w_period = r_custom_sel ? TIMER_W'({r_period_idx, r_custom_lo})
                                 : TIMER_W'(noise_period(r_period_idx));
`else
  // Without the custom period, SETUP[6] carries no meaning
  logic w_unused_custom_sel;
  assign w_unused_custom_sel = channel_regs_wr_data_i[6];

  assign w_period = TIMER_W'(noise_period(r_period_idx));
`endif

  assign w_tick = (r_timer == '0);

  // Down-counting timer; reload samples the period only at expiry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= w_period;
    end else begin
      r_timer <= r_timer - 1'b1;
    end
  end

  assign w_fb = r_lfsr[0] ^ (r_mode ? r_lfsr[SHORT_TAP] : r_lfsr[LONG_TAP]);

  // LFSR shifts right once per timer tick; seed 1 keeps it off all-zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= LFSR_W'(1);
    end else if (w_tick) begin
      r_lfsr <= {w_fb, r_lfsr[LFSR_W-1:1]};
    end
  end

  // Length counter: disable clears, load beats a coincident half-frame
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_length <= 8'd0;
    end else if (!channel_enabled_i) begin
      r_length <= 8'd0;
    end else if (w_wr_len) begin
      r_length <= length_value(channel_regs_wr_data_i[7:3]);
    end else if (half_frame_i && !r_halt && (r_length != 8'd0)) begin
      r_length <= r_length - 1'b1;
    end
  end

  apu_envelope_unit #(
    .VOL_W(VOL_W)
  ) u_env (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .quarter_frame_i(quarter_frame_i),
    .start_set_i    (w_wr_len),
    .loop_i         (r_halt),
    .const_vol_i    (r_const_vol),
    .volume_i       (VOL_W'(r_volume)),
    .level_o        (w_level)
  );

  assign w_scaled = OUT_W'(w_level) << (OUT_W - VOL_W);

  // Registered sample, silenced when LFSR bit 0 is set or length expired
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out <= '0;
    end else if (r_lfsr[0] || (r_length == 8'd0)) begin
      r_out <= '0;
    end else begin
      r_out <= w_scaled;
    end
  end

  assign channel_output_o    = r_out;
  assign channel_is_active_o = (r_length != 8'd0);

endmodule

// File: tb/tb_apu_noise_channel_ext.sv
// tb_apu_noise_channel_ext: directed and randomized checks of the noise
// channel against a cycle-level behavioural model kept in this file.
module tb_apu_noise_channel_ext;

  localparam int LFSR_W = 15;
  localparam int VOL_W  = 4;
  localparam int OUT_W  = 5;
  localparam int SCALE  = 1 << (OUT_W - VOL_W);

  // Reference tables written out from the channel description
  int periods [16] = '{3, 7, 15, 31, 63, 95, 127, 159, 201, 253, 379, 507,
                       761, 1015, 2033, 4067};
  int lengths [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12,
                       26, 14, 12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72,
                       26, 16, 28, 32, 30};

  // ---------------- clock / reset ----------------
  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             wr = 1'b0;
  logic [1:0]       addr = 2'd0;
  logic [7:0]       data = 8'd0;
  logic             half = 1'b0;
  logic             quarter = 1'b0;
  logic             en = 1'b0;
  logic             active;
  logic [OUT_W-1:0] out;

  always #5 clk_i = ~clk_i;

  apu_noise_channel_ext dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .channel_regs_wr_i     (wr),
    .channel_regs_addr_i   (addr),
    .channel_regs_wr_data_i(data),
    .half_frame_i          (half),
    .quarter_frame_i       (quarter),
    .channel_enabled_i     (en),
    .channel_is_active_o   (active),
    .channel_output_o      (out)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [OUT_W-1:0] exp_q[$];
  int m_lfsr, m_timer, m_len, m_start, m_div, m_decay;
  int c_halt, c_const, c_vol, c_mode, c_sel, c_idx, c_lo;

  task automatic model_reset();
    m_lfsr = 1; m_timer = 0; m_len = 0; m_start = 0; m_div = 0; m_decay = 0;
    c_halt = 0; c_const = 0; c_vol = 0; c_mode = 0; c_sel = 0; c_idx = 0; c_lo = 0;
    exp_q.delete();
  endtask

  function automatic int model_period();
    int p;
    p = periods[c_idx];
`ifdef APU_NOISE_CUSTOM_PERIOD_EN
    if (c_sel != 0) p = c_idx * 256 + c_lo;
`endif
    return p;
  endfunction

  task automatic model_step();
    int lvl, tap, fb;
    lvl = (c_const != 0) ? c_vol : m_decay;
    exp_q.push_back(((m_lfsr % 2) == 1 || m_len == 0) ? OUT_W'(0) : OUT_W'(lvl * SCALE));
    if (m_timer == 0) begin
      m_timer = model_period();
      tap = (c_mode != 0) ? 6 : 1;
      fb = (m_lfsr ^ (m_lfsr >> tap)) & 1;
      m_lfsr = (m_lfsr >> 1) | (fb << (LFSR_W - 1));
    end else begin
      m_timer = m_timer - 1;
    end
    if (!en) m_len = 0;
    else if (wr && addr == 2'd3) m_len = lengths[data[7:3]];
    else if (half && c_halt == 0 && m_len != 0) m_len = m_len - 1;
    if (quarter) begin
      if (m_start != 0) begin
        m_decay = 15; m_div = c_vol;
      end else if (m_div == 0) begin
        m_div = c_vol;
        if (m_decay != 0) m_decay = m_decay - 1;
        else if (c_halt != 0) m_decay = 15;
      end else begin
        m_div = m_div - 1;
      end
    end
    if (wr && addr == 2'd3) m_start = 1;
    else if (quarter) m_start = 0;
    if (wr) begin
      case (addr)
        2'd0: begin c_halt = int'(data[5]); c_const = int'(data[4]); c_vol = int'(data[3:0]); end
`ifdef APU_NOISE_CUSTOM_PERIOD_EN
        2'd1: c_lo = int'(data);
`endif
        2'd2: begin c_mode = int'(data[7]); c_sel = int'(data[6]); c_idx = int'(data[3:0]); end
        default: ;
      endcase
    end
  endtask

  // Model follows the DUT's clock and asynchronous reset
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) model_reset();
    else model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic scoreboard_check();
    logic [OUT_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("out", 32'(out), 32'(e));
    end
    check("active", 32'(active), 32'(m_len != 0));
    check("lfsr", 32'(dut.r_lfsr), 32'(m_lfsr));
    check("decay", 32'(dut.u_env.r_decay), 32'(m_decay));
  endtask

  // ---------------- drivers ----------------
  logic en_cur = 1'b1;

  task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d,
                      input logic h, input logic q, input logic e);
    wr = w; addr = a; data = d; half = h; quarter = q; en = e;
    @(negedge clk_i);
    scoreboard_check();
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, en_cur);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 1'b0, en_cur);
  endtask

  // Cycles between consecutive LFSR shifts once the new period is in force
  task automatic measure_interval(output int iv);
    logic [LFSR_W-1:0] prev;
    int changes, cnt, guard;
    iv = -1; changes = 0; cnt = 0; guard = 0;
    prev = dut.r_lfsr;
    while (changes < 3 && guard < 5000) begin
      idle();
      guard++; cnt++;
      if (dut.r_lfsr != prev) begin
        changes++;
        if (changes == 3) iv = cnt;
        cnt = 0;
        prev = dut.r_lfsr;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int iv, guard;
    logic w, h, q, e;
    logic [1:0] a;
    logic [7:0] d;

    repeat (3) @(negedge clk_i);
    check("rst_out", 32'(out), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_lfsr", 32'(dut.r_lfsr), 32'd1);
    rst_i = 1'b0;

    // First tick right after reset shifts seed 1 to 0x4000
    idle();
    check("lfsr_first_tick", 32'(dut.r_lfsr), 32'h4000);

    // Table period index 0: a shift every 4 cycles
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd0, 8'h1F);
    wr_reg(2'd3, 8'h08);
    measure_interval(iv);
    check("table_interval", 32'(iv), 32'd4);
    guard = 0;
    while (out == '0 && guard < 300) begin idle(); guard++; end
    check("out_const_15", 32'(out), 32'd30);

    // Asynchronous reset while the output is nonzero
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_active", 32'(active), 32'd0);
    check("async_rst_lfsr", 32'(dut.r_lfsr), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Mode 1 short sequence, checked cycle by cycle against the model
    wr_reg(2'd0, 8'h1F);
    wr_reg(2'd3, 8'h08);
    wr_reg(2'd2, 8'h80);
    repeat (400) idle();

    // Custom period select (or table index 2 when the feature is absent)
    wr_reg(2'd1, 8'h10);
    wr_reg(2'd2, 8'h42);
    measure_interval(iv);
`ifdef APU_NOISE_CUSTOM_PERIOD_EN
    check("custom_interval", 32'(iv), 32'd529);
`else
    check("custom_interval", 32'(iv), 32'd16);
`endif
    wr_reg(2'd2, 8'h00);

    // Length counter runs down from 254
    wr_reg(2'd0, 8'h0F);
    wr_reg(2'd3, 8'h08);
    repeat (253) step(1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    check("len_one_left", 32'(active), 32'd1);
    step(1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    check("len_expired", 32'(active), 32'd0);
    step(1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0);
    idle();
    check("len_load_disabled", 32'(active), 32'd0);
    step(1'b1, 2'd3, 8'h08, 1'b1, 1'b0, 1'b1);
    check("len_load_beats_half", 32'(dut.r_length), 32'd254);

    // Envelope with loop, volume 3
    wr_reg(2'd0, 8'h23);
    wr_reg(2'd3, 8'h08);
    step(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    check("env_start", 32'(dut.u_env.r_decay), 32'd15);
    repeat (4) step(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    check("env_first_dec", 32'(dut.u_env.r_decay), 32'd14);
    repeat (56) step(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    check("env_zero", 32'(dut.u_env.r_decay), 32'd0);
    repeat (4) step(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    check("env_wrap", 32'(dut.u_env.r_decay), 32'd15);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      if (a == 2'd2) d = d & 8'hC3;
      if (a == 2'd1) d = d & 8'h3F;
      h = ($urandom_range(0, 15) == 0);
      q = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 63) != 0);
      step(w, a, d, h, q, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
